// File: rtl/ones_count_sequencer_if.sv
// Bundle of the job handshake, the word stream and the link to the external 63-input ones counter.
// With THRESH_CMP_EN defined it also carries threshold / over_thresh.
interface ones_count_sequencer_if #(
  parameter int ACC_W = 8
);
  logic             start;
  logic             in_valid;
  logic [62:0]      in_data;
  logic             in_ready;
  logic [62:0]      pc_word;
  logic [5:0]       pc_sum;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] count;
`ifdef THRESH_CMP_EN
  logic [ACC_W-1:0] threshold;
  logic             over_thresh;

  modport master (
    output start, in_valid, in_data, pc_sum, threshold,
    input  in_ready, pc_word, busy, done, count, over_thresh
  );
  modport slave (
    input  start, in_valid, in_data, pc_sum, threshold,
    output in_ready, pc_word, busy, done, count, over_thresh
  );
`else
  modport master (
    output start, in_valid, in_data, pc_sum,
    input  in_ready, pc_word, busy, done, count
  );
  modport slave (
    input  start, in_valid, in_data, pc_sum,
    output in_ready, pc_word, busy, done, count
  );
`endif
endinterface

// File: rtl/ones_count_sequencer.sv
// Feeds NUM_WORDS 63-bit words one at a time through a shared external ones counter and totals the counts.
// Optional THRESH_CMP_EN adds a registered final-count >= threshold flag.
module ones_count_sequencer #(
  parameter int NUM_WORDS = 4,
  parameter int ACC_W     = 8
) (
  input logic                   clk,
  input logic                   rst,
  ones_count_sequencer_if.slave io_bus
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_SUM  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_word_idx;
  logic [ACC_W-1:0] r_count;
  logic [62:0]      r_pc_word;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic [ACC_W-1:0] w_sum_ext;
`ifdef THRESH_CMP_EN
  logic             r_over_thresh;
`endif

  assign w_sum_ext = ACC_W'(io_bus.pc_sum);

  // Job sequencer: all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_word_idx    <= '0;
      r_count       <= '0;
      r_pc_word     <= 63'd0;
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef THRESH_CMP_EN
      r_over_thresh <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_state       <= S_FEED;
            r_word_idx    <= '0;
            r_count       <= '0;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b1;
`ifdef THRESH_CMP_EN
            r_over_thresh <= 1'b0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FEED: begin
          if (io_bus.in_valid && r_in_ready) begin
            r_pc_word  <= io_bus.in_data;
            r_in_ready <= 1'b0;
            r_state    <= S_SUM;
          end else begin
            r_state <= S_FEED;
          end
        end
        S_SUM: begin
          // pc_sum is the external counter's combinational result for r_pc_word.
          r_count <= r_count + w_sum_ext;
          if (r_word_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_word_idx <= r_word_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            r_in_ready <= 1'b1;
            r_state    <= S_FEED;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
`ifdef THRESH_CMP_EN
          r_over_thresh <= (r_count >= io_bus.threshold);
`endif
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.in_ready = r_in_ready;
  assign io_bus.pc_word  = r_pc_word;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.count    = r_count;
`ifdef THRESH_CMP_EN
  assign io_bus.over_thresh = r_over_thresh;
`endif

endmodule

// File: tb/tb_ones_count_sequencer.sv
// Randomized self-checking bench for ones_count_sequencer (NUM_WORDS=4, ACC_W=8),
// with a behavioural ones counter on pc_word/pc_sum and a popcount-sum reference.
module tb_ones_count_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [62:0] words [0:3];

  ones_count_sequencer_if #(.ACC_W(8)) bus ();

  ones_count_sequencer #(.NUM_WORDS(4), .ACC_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // External 63-input ones counter.
  assign bus.pc_sum = 6'($countones(bus.pc_word));

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < 4; i++) t += $countones(words[i]);
    return t;
  endfunction

  function automatic logic [62:0] rand_word();
    logic [62:0] a;
    logic [62:0] b;
    a = 63'({$urandom(), $urandom()});
    b = 63'({$urandom(), $urandom()});
    case ($urandom_range(3, 0))
      0: return a & b;
      1: return a | b;
      2: return a;
      default: return (a == 63'd0) ? b : 63'd0;
    endcase
  endfunction

  // Runs one job of words[0..3]; gap = in_valid-low cycles before each word.
  task automatic drive_job(input int gap, input bit poke, output int cycles,
                           output bit stall_ok, output bit timed_out);
    int wait_n;
    cycles = 0; stall_ok = 1'b1; timed_out = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1; cycles++;
    bus.start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      wait_n = 0;
      while (bus.in_ready !== 1'b1 && wait_n < 8) begin
        @(posedge clk); #1; cycles++; wait_n++;
      end
      if (bus.in_ready !== 1'b1) timed_out = 1'b1;
      if (gap > 0) bus.in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if (poke && w == 1 && g == 0) bus.start = 1'b1;
        bus.in_data = rand_word();
        @(posedge clk); #1; cycles++;
        bus.start = 1'b0;
        if (bus.in_ready !== 1'b1) stall_ok = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = words[w];
      @(posedge clk); #1; cycles++;
      if (gap > 0) bus.in_valid = 1'b0;
    end
    wait_n = 0;
    while (bus.done !== 1'b1 && wait_n < 8) begin
      @(posedge clk); #1; cycles++; wait_n++;
    end
    if (bus.done !== 1'b1) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    n_tests++; if (bus.pc_word !== 63'd0) begin n_fail++; $display("FAIL reset_pc_word got %h exp 0", bus.pc_word); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    int cyc; bit sok; bit to;
    for (int i = 0; i < 4; i++) words[i] = 63'h7FFF_FFFF_FFFF_FFFF;
    drive_job(0, 1'b0, cyc, sok, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL ones_timeout got %b exp 0", to); end
    n_tests++; if (cyc != 9) begin n_fail++; $display("FAIL ones_latency got %0d exp 9", cyc); end
    n_tests++; if (bus.count !== 8'hFC) begin n_fail++; $display("FAIL ones_count got %0d exp 252", bus.count); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ones_busy_in_done got %b exp 0", bus.busy); end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL ones_done_pulse got %b exp 0", bus.done); end
    n_tests++; if (bus.pc_word !== words[3]) begin n_fail++; $display("FAIL ones_pc_word_hold got %h exp %h", bus.pc_word, words[3]); end
  endtask

  task automatic test_patterns();
    int cyc; bit sok; bit to;
    words[0] = 63'h0;
    words[1] = 63'h1;
    words[2] = 63'h7FFF_FFFF_FFFF_FFFF;
    words[3] = 63'h5555_5555_5555_5555;
    drive_job(0, 1'b0, cyc, sok, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL pat_timeout got %b exp 0", to); end
    n_tests++; if (bus.count !== 8'd96) begin n_fail++; $display("FAIL pat_count got %0d exp 96", bus.count); end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.count !== 8'd96) begin n_fail++; $display("FAIL pat_count_held got %0d exp 96", bus.count); end
  endtask

  task automatic test_stall();
    int cyc; bit sok; bit to; int exp;
    for (int i = 0; i < 4; i++) words[i] = rand_word();
    exp = model_total();
    drive_job(3, 1'b1, cyc, sok, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %b exp 0", to); end
    n_tests++; if (sok !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready got %b exp 1", sok); end
    n_tests++; if (cyc != 21) begin n_fail++; $display("FAIL stall_latency got %0d exp 21", cyc); end
    n_tests++; if (bus.count !== 8'(exp)) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", bus.count, exp); end
    // start during the DONE cycle must be dropped
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_busy got %b exp 0", bus.busy); end
    @(posedge clk); #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL start_in_done_ready got %b exp 0", bus.in_ready); end
    n_tests++; if (bus.count !== 8'(exp)) begin n_fail++; $display("FAIL start_in_done_count got %0d exp %0d", bus.count, exp); end
  endtask

  task automatic test_mid_reset();
    int cyc; bit sok; bit to; int exp; int wait_n;
    for (int i = 0; i < 4; i++) words[i] = 63'h7FFF_FFFF_FFFF_FFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      wait_n = 0;
      while (bus.in_ready !== 1'b1 && wait_n < 8) begin
        @(posedge clk); #1; wait_n++;
      end
      bus.in_data = words[w];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", bus.count); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %b exp 0", bus.in_ready); end
    n_tests++; if (bus.pc_word !== 63'd0) begin n_fail++; $display("FAIL midrst_pc_word got %h exp 0", bus.pc_word); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.count !== 8'd0) begin n_fail++; $display("FAIL midrst_count_idle got %0d exp 0", bus.count); end
    for (int i = 0; i < 4; i++) words[i] = rand_word();
    exp = model_total();
    drive_job(1, 1'b0, cyc, sok, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL midrst_new_timeout got %b exp 0", to); end
    n_tests++; if (bus.count !== 8'(exp)) begin n_fail++; $display("FAIL midrst_new_count got %0d exp %0d", bus.count, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int cyc; bit sok; bit to; int exp; int gap;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 4; i++) words[i] = rand_word();
      exp = model_total();
      gap = $urandom_range(2, 0);
      drive_job(gap, 1'b0, cyc, sok, to);
      bus.in_valid = 1'b0;
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand_timeout job %0d got %b exp 0", j, to); end
      n_tests++; if (bus.count !== 8'(exp)) begin n_fail++; $display("FAIL rand_count job %0d got %0d exp %0d", j, bus.count, exp); end
      n_tests++; if (sok !== 1'b1) begin n_fail++; $display("FAIL rand_stall job %0d got %b exp 1", j, sok); end
      repeat ($urandom_range(2, 1)) @(posedge clk);
      #1;
    end
  endtask

`ifdef THRESH_CMP_EN
  task automatic test_thresh();
    int cyc; bit sok; bit to;
    words[0] = 63'h0;
    words[1] = 63'h1;
    words[2] = 63'h7FFF_FFFF_FFFF_FFFF;
    words[3] = 63'h5555_5555_5555_5555;
    bus.threshold = 8'd100;
    drive_job(0, 1'b0, cyc, sok, to);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (bus.over_thresh !== 1'b0) begin n_fail++; $display("FAIL thresh_100 got %b exp 0", bus.over_thresh); end
    bus.threshold = 8'd96;
    drive_job(1, 1'b0, cyc, sok, to);
    @(posedge clk); #1;
    n_tests++; if (bus.over_thresh !== 1'b1) begin n_fail++; $display("FAIL thresh_96 got %b exp 1", bus.over_thresh); end
    bus.threshold = 8'd200;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.over_thresh !== 1'b1) begin n_fail++; $display("FAIL thresh_hold got %b exp 1", bus.over_thresh); end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_tests++; if (bus.over_thresh !== 1'b0) begin n_fail++; $display("FAIL thresh_clear got %b exp 0", bus.over_thresh); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
`endif

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 63'd0;
`ifdef THRESH_CMP_EN
    bus.threshold = 8'd0;
`endif
    test_reset();
    test_all_ones();
    test_patterns();
    test_stall();
    test_mid_reset();
    test_random();
`ifdef THRESH_CMP_EN
    test_thresh();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
